// File: rtl/frame_latency_meter_pkg.sv
// Shared types and default parameters for the display latency meter.
package frame_latency_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FLASH,
        WAIT
    } meter_state_t;

    localparam int unsigned DEFAULT_CNT_WIDTH   = 32;
    localparam int unsigned DEFAULT_TIMEOUT     = 100000000;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    function automatic logic isBusy(input meter_state_t state);
        return (state == ARM) || (state == FLASH) || (state == WAIT);
    endfunction

endpackage

// File: rtl/frame_latency_meter_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with a registered-history
// rising-edge pulse on the synchronised side.
module sync_edge
    import frame_latency_meter_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clock,
    input  logic resetn,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_edge: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/frame_latency_meter.sv
// Display latency meter: flashes one white frame and counts pixel clocks from
// that frame's start until the photodiode sees light.
module frame_latency_meter
    import frame_latency_meter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 vsync,
    input  logic                 vsync_pol,
    input  logic                 sensor,
    input  logic                 start,
    output logic                 flash,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 timeout,
    output logic [15:0]          frame_count
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("frame_latency_meter: TIMEOUT must be at least 2");
    end
    if (CNT_WIDTH < 64 && 64'(TIMEOUT) >= (64'd1 << CNT_WIDTH)) begin : g_bad_width
        $error("frame_latency_meter: TIMEOUT does not fit in CNT_WIDTH bits");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    meter_state_t         state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] result_q;
    logic                 flash_q;
    logic                 valid_q;
    logic                 timeout_q;
    logic [15:0]          frame_count_q;
    logic [15:0]          frame_count_d;

    logic vs_act;
    logic vs_act_q;
    logic fs;
    logic sens_s;
    logic sens_rise;
    logic srise;

    // vsync is already in this clock domain, so only its leading edge is needed.
    assign vs_act        = (vsync == vsync_pol);
    assign fs            = vs_act & ~vs_act_q;
    assign frame_count_d = fs ? frame_count_q + 16'd1 : frame_count_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            vs_act_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            vs_act_q      <= vs_act;
            frame_count_q <= frame_count_d;
        end
    end

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sensor_sync (
        .clock   (clock),
        .resetn  (resetn),
        .d_i     (sensor),
        .level_o (sens_s),
        .rise_o  (sens_rise)
    );

    assign srise = sens_rise & sens_s;

    // A sensor rise takes priority over the timeout when both land together.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            flash_q   <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (fs) begin
                        state_q <= FLASH;
                        cnt_q   <= '0;
                        flash_q <= 1'b1;
                    end
                end
                FLASH, WAIT: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (srise) begin
                        result_q <= cnt_q;
                        valid_q  <= 1'b1;
                        flash_q  <= 1'b0;
                        state_q  <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q  <= '1;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        flash_q   <= 1'b0;
                        state_q   <= IDLE;
                    end else if (state_q == FLASH && fs) begin
                        flash_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    flash_q <= 1'b0;
                end
            endcase
        end
    end

    assign flash        = flash_q;
    assign busy         = isBusy(state_q);
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout      = timeout_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_frame_latency_meter.sv
// Directed bench for frame_latency_meter: 100-cycle frames, TIMEOUT=500, two-stage sensor sync.
module tb_frame_latency_meter;

    logic        clock = 1'b0;
    logic        resetn;
    logic        vsync;
    logic        vsync_pol;
    logic        sensor;
    logic        start;
    logic        flash;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        timeout;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;
    int phase;
    bit vsEnable;
    bit fsEdge;
    int pulses;
    logic [31:0] captured;
    bit seenValid;

    always #5 clock = ~clock;

    frame_latency_meter #(
        .CNT_WIDTH   (32),
        .TIMEOUT     (500),
        .SYNC_STAGES (2)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .vsync        (vsync),
        .vsync_pol    (vsync_pol),
        .sensor       (sensor),
        .start        (start),
        .flash        (flash),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .frame_count  (frame_count)
    );

    task automatic driveVsync();
        vsync = (vsEnable && phase < 2) ? vsync_pol : ~vsync_pol;
    endtask

    // fsEdge marks that the edge just passed sampled the first active vsync cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        fsEdge = vsEnable && (phase == 0);
        phase  = (phase + 1) % 100;
        driveVsync();
    endtask

    task automatic applyStimulus(input logic st, input logic sens);
        start  = st;
        sensor = sens;
        tick();
        start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitFlash(input string tag);
        int n = 0;
        while (flash !== 1'b1 && n < 250) begin
            tick();
            n++;
        end
        checkOutput({tag, "FlashRise"}, {31'd0, flash}, 32'd1);
        checkOutput({tag, "FsAlign"}, {31'd0, fsEdge}, 32'd1);
    endtask

    initial begin
        resetn    = 1'b0;
        vsync_pol = 1'b1;
        sensor    = 1'b0;
        start     = 1'b0;
        vsEnable  = 1'b0;
        phase     = 99;
        fsEdge    = 1'b0;
        driveVsync();
        repeat (3) tick();
        checkOutput("rstFlash", {31'd0, flash}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstResult", result, 32'd0);
        checkOutput("rstValid", {31'd0, result_valid}, 32'd0);
        checkOutput("rstTimeout", {31'd0, timeout}, 32'd0);
        checkOutput("rstFrames", {16'd0, frame_count}, 32'd0);
        resetn = 1'b1;

        // Frame counting: one increment per frame, not per active vsync cycle.
        phase    = 99;
        vsEnable = 1'b1;
        driveVsync();
        tick();
        tick();
        checkOutput("fcFirst", {16'd0, frame_count}, 32'd1);
        tick();
        checkOutput("fcSecondHigh", {16'd0, frame_count}, 32'd1);
        repeat (297) tick();
        checkOutput("fcThree", {16'd0, frame_count}, 32'd3);

        // Normal measurement: sensor rises 250 cycles after fs -> 252.
        repeat (10) tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("armBusy", {31'd0, busy}, 32'd1);
        checkOutput("armFlash", {31'd0, flash}, 32'd0);
        waitFlash("norm");
        checkOutput("flashBusy", {31'd0, busy}, 32'd1);
        repeat (99) tick();
        checkOutput("flashHeld", {31'd0, flash}, 32'd1);
        tick();
        checkOutput("flashFall", {31'd0, flash}, 32'd0);
        checkOutput("waitBusy", {31'd0, busy}, 32'd1);
        repeat (150) tick();
        sensor = 1'b1;
        tick();
        tick();
        checkOutput("noEarlyValid", {31'd0, result_valid}, 32'd0);
        tick();
        checkOutput("normValid", {31'd0, result_valid}, 32'd1);
        checkOutput("normResult", result, 32'd252);
        checkOutput("normNoTimeout", {31'd0, timeout}, 32'd0);
        checkOutput("normIdle", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("normValidDrop", {31'd0, result_valid}, 32'd0);
        checkOutput("normHold", result, 32'd252);
        sensor = 1'b0;
        repeat (3) tick();

        // Timeout with the sensor dark.
        applyStimulus(1'b1, 1'b0);
        waitFlash("to");
        repeat (499) tick();
        checkOutput("toNotYet", {31'd0, result_valid}, 32'd0);
        checkOutput("toStillBusy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("toValid", {31'd0, result_valid}, 32'd1);
        checkOutput("toFlag", {31'd0, timeout}, 32'd1);
        checkOutput("toResult", result, 32'hFFFF_FFFF);
        checkOutput("toIdle", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("toValidDrop", {31'd0, result_valid}, 32'd0);
        checkOutput("toFlagDrop", {31'd0, timeout}, 32'd0);

        // Sensor already high before arming: no rising edge, so it times out.
        sensor = 1'b1;
        repeat (5) tick();
        applyStimulus(1'b1, 1'b1);
        waitFlash("held");
        repeat (499) tick();
        checkOutput("heldBusy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("heldTimeout", {31'd0, timeout}, 32'd1);
        sensor = 1'b0;
        repeat (5) tick();

        // Sensor pulse confined to ARM is ignored.
        while (phase != 1) tick();
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0);
        checkOutput("armPulseBusy", {31'd0, busy}, 32'd1);
        checkOutput("armPulseNoValid", {31'd0, result_valid}, 32'd0);
        waitFlash("armp");
        repeat (500) tick();
        checkOutput("armPulseTimeout", {31'd0, timeout}, 32'd1);
        repeat (3) tick();

        // Reset in the middle of FLASH.
        applyStimulus(1'b1, 1'b0);
        waitFlash("rst");
        repeat (20) tick();
        resetn = 1'b0;
        tick();
        checkOutput("midRstFlash", {31'd0, flash}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstResult", result, 32'd0);
        checkOutput("midRstValid", {31'd0, result_valid}, 32'd0);
        checkOutput("midRstTimeout", {31'd0, timeout}, 32'd0);
        checkOutput("midRstFrames", {16'd0, frame_count}, 32'd0);
        resetn    = 1'b1;
        sensor    = 1'b1;
        seenValid = 1'b0;
        repeat (10) begin
            tick();
            seenValid |= result_valid;
        end
        checkOutput("postRstNoValid", {31'd0, seenValid}, 32'd0);
        checkOutput("postRstIdle", {31'd0, busy}, 32'd0);
        sensor = 1'b0;
        repeat (5) tick();

        // Start pulses while busy are ignored; exactly one result of 32.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitFlash("filt");
        repeat (4) tick();
        applyStimulus(1'b1, 1'b0);
        repeat (25) tick();
        sensor   = 1'b1;
        pulses   = 0;
        captured = 32'd0;
        repeat (200) begin
            tick();
            if (result_valid === 1'b1) begin
                pulses++;
                captured = result;
            end
        end
        checkOutput("filtPulses", pulses, 32'd1);
        checkOutput("filtResult", captured, 32'd32);
        checkOutput("filtIdle", {31'd0, busy}, 32'd0);
        sensor = 1'b0;
        repeat (3) tick();

        // Active-low vsync gives the same measurement.
        vsync_pol = 1'b0;
        driveVsync();
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0);
        waitFlash("pol");
        repeat (99) tick();
        checkOutput("polFlashHeld", {31'd0, flash}, 32'd1);
        tick();
        checkOutput("polFlashFall", {31'd0, flash}, 32'd0);
        repeat (150) tick();
        sensor = 1'b1;
        repeat (3) tick();
        checkOutput("polValid", {31'd0, result_valid}, 32'd1);
        checkOutput("polResult", result, 32'd252);
        checkOutput("polIdle", {31'd0, busy}, 32'd0);
        sensor = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
